vm_change_dispenser: RTL and testbench
======================================

// Module: vm_change_dispenser
// PURPOSE
//  Sequences the vending machine's change stream onto the physical coin/note hopper.
//  Buffers denomination codes from the vending FSM (code+valid pulses) in a small FIFO.
//  Issues one hopper eject at a time and waits for a sense acknowledge.
//  Times out and retries a missing acknowledge, then latches a fault for the service bus.
// PARAMETERS
//  FIFO_DEPTH      16    change-code FIFO entries; power of two, >=2
//  TIMEOUT_CYCLES  1000  max cycles o_eject_req stays high awaiting i_eject_done
//  MAX_RETRIES     2     re-issues after a timeout before declaring fault (0 = none)
//  SETTLE_CYCLES   4     idle gap after every eject attempt (mechanical settle), >=1
// PORTS
//  i_clk            in   1  system clock
//  i_rst            in   1  reset, asynchronous, active-high
//  i_change_code    in   4  denomination code 1..15 from vending FSM
//  i_change_valid   in   1  i_change_code valid this cycle
//  i_no_change      in   1  qualifies i_change_valid: machine could not make change
//  i_eject_done     in   1  hopper sensor: one unit ejected (level or pulse)
//  i_fault_clr      in   1  service clear of o_fault/o_overflow/o_shortage
//  o_eject_code     out  4  denomination to eject; stable while o_eject_req=1
//  o_eject_req      out  1  eject request to hopper
//  o_busy           out  1  FSM not IDLE or FIFO non-empty
//  o_fault          out  1  sticky: eject failed after all retries
//  o_fault_code     out  4  denomination that faulted
//  o_overflow       out  1  sticky: change code dropped, FIFO full
//  o_shortage       out  1  sticky: i_no_change seen with i_change_valid
//  o_dispensed_cnt  out  8  successful ejects since reset, wraps 255->0
// BEHAVIOUR
//  Reset (i_rst=1, any time, mid-eject included): all outputs 0, FIFO empty,
//   FSM IDLE, retry/timeout/settle counters 0. o_eject_req drops on i_rst assertion.
//  Write: i_change_valid=1 & i_no_change=0 & code!=0 pushes the code.
//   code==0 is ignored. valid & no_change: no push, set o_shortage.
//   Full FIFO: the push is dropped and o_overflow is set,
//   unless a pop occurs in the same cycle; then the push is accepted.
//  FSM states: IDLE, REQ, SETTLE, FAULT.
//  IDLE: FIFO non-empty -> pop to code register, clear retry count, -> REQ.
//   Latency: valid at edge N; o_eject_req=1 from cycle after edge N+1 (2 clocks).
//  REQ: o_eject_req=1, o_eject_code=held code, timeout counter increments.
//   i_eject_done=1 -> o_dispensed_cnt++, -> SETTLE (no reissue).
//   No done after TIMEOUT_CYCLES cycles high -> timeout:
//    retries<MAX_RETRIES -> retries++, -> SETTLE with reissue flag set.
//    Otherwise -> FAULT, with o_fault=1 and o_fault_code=held code.
//   done in the same cycle as timeout expiry: done wins.
//  SETTLE: o_eject_req=0 for exactly SETTLE_CYCLES cycles.
//   Then: reissue flag set -> REQ with the same code and timeout reset.
//   Otherwise -> IDLE.
//  FAULT: no ejects; FIFO keeps accepting writes (overflow rules apply).
//   i_fault_clr=1 -> clear o_fault/o_fault_code, discard the faulted code, -> IDLE.
//  i_fault_clr in any state also clears o_overflow and o_shortage.
//   A set event in the same cycle as clear wins.
//  i_eject_done outside REQ: ignored; does not count.
//  One eject outstanding at most; FIFO order preserved; no reordering.
// TESTING
//  T1 idle, push code 3 at edge 0, done 5 cycles after req -> req high cycles 2..6,
//     code=3, cnt=1, req low 4 cycles, then IDLE, busy=0.
//  T2 push 1,1,3,9,15 back-to-back, done after 1 cycle each -> ejects in order 1,1,3,9,15,
//     SETTLE gap 4 cycles between, cnt=5.
//  T3 TIMEOUT_CYCLES=10, never done -> req high 10 cycles, 3 attempts total,
//     then o_fault=1, fault_code=code; fault_clr -> IDLE, next FIFO code ejected.
//  T4 push 17 codes while FAULT with depth 16 -> 16 stored, o_overflow=1;
//     write-on-pop while full accepted, no overflow.
//  T5 valid+no_change -> o_shortage=1, no push; code 0 -> ignored; done while IDLE -> cnt unchanged.
//  T6 i_rst mid-REQ -> req drops at once, FIFO empty, all outputs 0; recovers on next push.

Source files
------------

// File: rtl/vm_change_dispenser_if.sv
// vm_change_dispenser_if
//   Groups the change-dispenser signals: the vending FSM write port, the hopper
//   eject handshake and the service/status bus. Names follow the dispenser's
//   point of view (i_ = into the dispenser, o_ = out of it).
//   Modports:
//     slave  - the dispenser itself
//     master - the environment (vending FSM, hopper, service bus)
//   Signals:
//     i_change_code[3:0]   denomination code 1..15
//     i_change_valid       code valid this cycle
//     i_no_change          machine could not make change (qualifies valid)
//     i_eject_done         hopper sensor acknowledge
//     i_fault_clr          service clear of sticky flags
//     o_eject_code[3:0]    denomination being ejected
//     o_eject_req          eject request to hopper
//     o_busy               FSM active or FIFO non-empty
//     o_fault              sticky eject fault
//     o_fault_code[3:0]    denomination that faulted
//     o_overflow           sticky FIFO overflow
//     o_shortage           sticky shortage indication
//     o_dispensed_cnt[7:0] successful ejects since reset
interface vm_change_dispenser_if;
  logic [3:0] i_change_code;
  logic       i_change_valid;
  logic       i_no_change;
  logic       i_eject_done;
  logic       i_fault_clr;
  logic [3:0] o_eject_code;
  logic       o_eject_req;
  logic       o_busy;
  logic       o_fault;
  logic [3:0] o_fault_code;
  logic       o_overflow;
  logic       o_shortage;
  logic [7:0] o_dispensed_cnt;

  modport slave (
    input  i_change_code, i_change_valid, i_no_change, i_eject_done, i_fault_clr,
    output o_eject_code, o_eject_req, o_busy, o_fault, o_fault_code,
           o_overflow, o_shortage, o_dispensed_cnt
  );

  modport master (
    output i_change_code, i_change_valid, i_no_change, i_eject_done, i_fault_clr,
    input  o_eject_code, o_eject_req, o_busy, o_fault, o_fault_code,
           o_overflow, o_shortage, o_dispensed_cnt
  );
endinterface

// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser
//   Buffers change denomination codes from the vending FSM in a FIFO and feeds
//   them one at a time to the coin/note hopper. Each eject waits for the hopper
//   sense acknowledge; a missing acknowledge is retried after a settle gap and,
//   once retries are exhausted, a sticky fault is latched for the service bus.
//   Ports:
//     i_clk  - system clock
//     i_rst  - asynchronous active-high reset
//     bus    - vm_change_dispenser_if.slave (write port, hopper handshake, status)
//
//   state  | meaning
//   IDLE   | waiting for a buffered code; pops it into the code register
//   REQ    | o_eject_req high, timeout down-counter running
//   SETTLE | request low for SETTLE_CYCLES; reissues same code after a timeout
//   FAULT  | retries exhausted; ejects halted until i_fault_clr
module vm_change_dispenser #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRIES    = 2,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  vm_change_dispenser_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic [1:0]    r_state;
  logic [3:0]    r_code;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_settle;
  logic [RW-1:0] r_retries;
  logic          r_reissue;
  logic          r_fault;
  logic [3:0]    r_fault_code;
  logic          r_overflow;
  logic          r_shortage;
  logic [7:0]    r_cnt;

  logic w_want_push;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_short;
  logic w_can_retry;
  logic w_set_fault;

  assign w_want_push = bus.i_change_valid & ~bus.i_no_change & (bus.i_change_code != 4'd0);
  assign w_short     = bus.i_change_valid & bus.i_no_change;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign w_push      = w_want_push & (~w_full | w_pop);
  assign w_drop      = w_want_push & w_full & ~w_pop;
  assign w_can_retry = (r_retries < RW'(MAX_RETRIES));
  assign w_set_fault = (r_state == S_REQ) & ~bus.i_eject_done & (r_timer == '0) & ~w_can_retry;

  // Storage carries no reset; emptiness is defined purely by the pointers/count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.i_change_code;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_code    <= '0;
      r_timer   <= '0;
      r_settle  <= '0;
      r_retries <= '0;
      r_reissue <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_code    <= r_mem[r_rd_ptr];
            r_retries <= '0;
            r_reissue <= 1'b0;
            r_timer   <= TW'(TIMEOUT_CYCLES - 1);
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          // Acknowledge takes priority over a timeout expiring in the same cycle.
          if (bus.i_eject_done) begin
            r_cnt     <= r_cnt + 8'd1;
            r_reissue <= 1'b0;
            r_settle  <= SW'(SETTLE_CYCLES - 1);
            r_state   <= S_SETTLE;
          end else if (r_timer == '0) begin
            if (w_can_retry) begin
              r_retries <= r_retries + RW'(1);
              r_reissue <= 1'b1;
              r_settle  <= SW'(SETTLE_CYCLES - 1);
              r_state   <= S_SETTLE;
            end else begin
              r_state <= S_FAULT;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_SETTLE: begin
          if (r_settle == '0) begin
            if (r_reissue) begin
              r_reissue <= 1'b0;
              r_timer   <= TW'(TIMEOUT_CYCLES - 1);
              r_state   <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_settle <= r_settle - SW'(1);
          end
        end
        S_FAULT: begin
          if (bus.i_fault_clr) begin
            r_code  <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky status: a set event in the same cycle as a clear wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fault      <= 1'b0;
      r_fault_code <= '0;
      r_overflow   <= 1'b0;
      r_shortage   <= 1'b0;
    end else begin
      if (w_set_fault) begin
        r_fault      <= 1'b1;
        r_fault_code <= r_code;
      end else if (bus.i_fault_clr) begin
        r_fault      <= 1'b0;
        r_fault_code <= '0;
      end
      if (w_drop)                r_overflow <= 1'b1;
      else if (bus.i_fault_clr)  r_overflow <= 1'b0;
      if (w_short)               r_shortage <= 1'b1;
      else if (bus.i_fault_clr)  r_shortage <= 1'b0;
    end
  end

  assign bus.o_eject_req     = (r_state == S_REQ);
  assign bus.o_eject_code    = r_code;
  assign bus.o_busy          = (r_state != S_IDLE) | ~w_empty;
  assign bus.o_fault         = r_fault;
  assign bus.o_fault_code    = r_fault_code;
  assign bus.o_overflow      = r_overflow;
  assign bus.o_shortage      = r_shortage;
  assign bus.o_dispensed_cnt = r_cnt;

endmodule

// File: tb/tb_vm_change_dispenser.sv
module tb_vm_change_dispenser;
  localparam int DEPTH   = 16;
  localparam int TMO     = 10;
  localparam int RETRIES = 2;
  localparam int SETTLE  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vm_change_dispenser_if ifc();

  vm_change_dispenser #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RETRIES), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(ifc.slave)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q[$];      // codes the hopper should see, in order
  int exp_cnt  = 0;  // successful ejects since last reset
  bit push_done = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.i_change_code  = 4'd0;
    ifc.i_change_valid = 1'b0;
    ifc.i_no_change    = 1'b0;
    ifc.i_eject_done   = 1'b0;
    ifc.i_fault_clr    = 1'b0;
  endtask

  task automatic push_code(input int c);
    ifc.i_change_code  = 4'(c);
    ifc.i_change_valid = 1'b1;
    tick();
    ifc.i_change_valid = 1'b0;
  endtask

  // Acts as the hopper: acknowledges each request after a random delay shorter
  // than the timeout and checks order, settle gap and the dispensed count.
  task automatic run_hopper(input int delay_max, input int budget);
    int age, tgt, low, cyc, e;
    bit prev, seen;
    age = 0; low = 0; cyc = 0; prev = 0; seen = 0;
    tgt = $urandom_range(delay_max, 0);
    while (cyc < budget) begin
      if (push_done && exp_q.size() == 0 && !ifc.o_busy && !ifc.o_eject_req) break;
      if (ifc.o_eject_req) begin
        if (!prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL hopper_unexpected_eject got code=%0d expected none", ifc.o_eject_code);
          end else begin
            e = exp_q.pop_front();
            if (ifc.o_eject_code !== 4'(e)) begin
              failures++;
              $display("FAIL hopper_order got code=%0d expected %0d", ifc.o_eject_code, e);
            end
          end
          if (seen) begin
            checks++;
            if (low < SETTLE) begin
              failures++;
              $display("FAIL hopper_settle_gap got %0d low cycles expected >= %0d", low, SETTLE);
            end
          end
          seen = 1; age = 0;
          tgt = $urandom_range(delay_max, 0);
        end
        if (age == tgt) begin
          ifc.i_eject_done = 1'b1;
          exp_cnt++;
        end else begin
          ifc.i_eject_done = 1'b0;
        end
        age++;
        low = 0;
      end else begin
        ifc.i_eject_done = 1'b0;
        low++;
      end
      prev = ifc.o_eject_req;
      tick();
      cyc++;
    end
    ifc.i_eject_done = 1'b0;
    checks++;
    if (cyc >= budget) begin
      failures++;
      $display("FAIL hopper_budget got %0d codes still pending busy=%0b expected drained", exp_q.size(), ifc.o_busy);
    end
    checks++;
    if (ifc.o_dispensed_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL hopper_count got %0d expected %0d", ifc.o_dispensed_cnt, 8'(exp_cnt));
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ifc.o_eject_req, ifc.o_busy, ifc.o_fault, ifc.o_overflow, ifc.o_shortage} !== 5'b0 ||
        ifc.o_eject_code !== 4'd0 || ifc.o_fault_code !== 4'd0 || ifc.o_dispensed_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got req=%0b busy=%0b fault=%0b ovf=%0b short=%0b code=%0d fcode=%0d cnt=%0d expected all 0",
               ifc.o_eject_req, ifc.o_busy, ifc.o_fault, ifc.o_overflow, ifc.o_shortage,
               ifc.o_eject_code, ifc.o_fault_code, ifc.o_dispensed_cnt);
    end
    rst = 1'b0;
    exp_cnt = 0;
    tick();
    checks++;
    if (ifc.o_busy !== 1'b0 || ifc.o_eject_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got busy=%0b req=%0b expected 0 0", ifc.o_busy, ifc.o_eject_req);
    end
  endtask

  task automatic test_single();
    bit ok;
    push_code(3);
    checks++;
    if (ifc.o_eject_req !== 1'b0) begin
      failures++;
      $display("FAIL t1_req_early got %0b expected 0", ifc.o_eject_req);
    end
    tick();
    checks++;
    if (ifc.o_eject_req !== 1'b1 || ifc.o_eject_code !== 4'd3) begin
      failures++;
      $display("FAIL t1_req_rise got req=%0b code=%0d expected 1 3", ifc.o_eject_req, ifc.o_eject_code);
    end
    ok = 1;
    repeat (4) begin
      tick();
      if (ifc.o_eject_req !== 1'b1 || ifc.o_eject_code !== 4'd3) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL t1_req_hold got req dropped or code changed expected req=1 code=3 for 5 cycles");
    end
    ifc.i_eject_done = 1'b1;
    exp_cnt++;
    tick();
    ifc.i_eject_done = 1'b0;
    checks++;
    if (ifc.o_eject_req !== 1'b0 || ifc.o_dispensed_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL t1_done got req=%0b cnt=%0d expected 0 %0d", ifc.o_eject_req, ifc.o_dispensed_cnt, exp_cnt);
    end
    ok = 1;
    repeat (SETTLE - 1) begin
      tick();
      if (ifc.o_eject_req !== 1'b0 || ifc.o_busy !== 1'b1) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL t1_settle got early exit or req expected busy=1 req=0 for %0d cycles", SETTLE);
    end
    tick();
    checks++;
    if (ifc.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL t1_idle got busy=%0b expected 0", ifc.o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int codes[5];
    codes = '{1, 1, 3, 9, 15};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(codes[i]);
      push_code(codes[i]);
    end
    push_done = 1;
    run_hopper(0, 300);
  endtask

  task automatic test_timeout();
    int hi, lo;
    bit ok;
    push_code(7);
    for (int a = 0; a < RETRIES + 1; a++) begin
      lo = 0;
      while (!ifc.o_eject_req && lo < 100) begin tick(); lo++; end
      checks++;
      if (ifc.o_eject_req !== 1'b1) begin
        failures++;
        $display("FAIL t3_attempt_missing attempt=%0d got req=0 expected 1", a);
      end
      if (a > 0) begin
        checks++;
        if (lo != SETTLE) begin
          failures++;
          $display("FAIL t3_retry_gap got %0d expected %0d", lo, SETTLE);
        end
      end
      hi = 0; ok = 1;
      while (ifc.o_eject_req && hi < 100) begin
        if (ifc.o_eject_code !== 4'd7) ok = 0;
        tick(); hi++;
      end
      checks++;
      if (hi != TMO || !ok) begin
        failures++;
        $display("FAIL t3_req_len got %0d cycles code_ok=%0b expected %0d 1", hi, ok, TMO);
      end
      checks++;
      if (ifc.o_fault !== (a == RETRIES)) begin
        failures++;
        $display("FAIL t3_fault_flag attempt=%0d got %0b expected %0b", a, ifc.o_fault, (a == RETRIES));
      end
    end
    checks++;
    if (ifc.o_fault_code !== 4'd7) begin
      failures++;
      $display("FAIL t3_fault_code got %0d expected 7", ifc.o_fault_code);
    end
    push_code(12);
    exp_q.push_back(12);
    ok = 1;
    repeat (20) begin
      tick();
      if (ifc.o_eject_req !== 1'b0 || ifc.o_busy !== 1'b1 || ifc.o_fault !== 1'b1) ok = 0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL t3_fault_hold got req or flag change expected req=0 busy=1 fault=1");
    end
    ifc.i_fault_clr = 1'b1;
    tick();
    ifc.i_fault_clr = 1'b0;
    checks++;
    if (ifc.o_fault !== 1'b0 || ifc.o_fault_code !== 4'd0) begin
      failures++;
      $display("FAIL t3_fault_clr got fault=%0b fcode=%0d expected 0 0", ifc.o_fault, ifc.o_fault_code);
    end
    push_done = 1;
    run_hopper(3, 200);
  endtask

  task automatic go_fault(input int c);
    int n;
    n = 0;
    push_code(c);
    while (!ifc.o_fault && n < 300) begin tick(); n++; end
    checks++;
    if (ifc.o_fault !== 1'b1) begin
      failures++;
      $display("FAIL reach_fault got fault=%0b expected 1", ifc.o_fault);
    end
  endtask

  task automatic test_overflow();
    int c;
    go_fault(5);
    for (int i = 0; i < DEPTH + 1; i++) begin
      c = $urandom_range(15, 1);
      if (i < DEPTH) exp_q.push_back(c);
      push_code(c);
      if (i == DEPTH - 1) begin
        checks++;
        if (ifc.o_overflow !== 1'b0) begin
          failures++;
          $display("FAIL t4_ovf_early got %0b expected 0", ifc.o_overflow);
        end
      end
    end
    checks++;
    if (ifc.o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL t4_ovf_set got %0b expected 1", ifc.o_overflow);
    end
    ifc.i_fault_clr = 1'b1;
    tick();
    ifc.i_fault_clr = 1'b0;
    checks++;
    if (ifc.o_overflow !== 1'b0 || ifc.o_fault !== 1'b0) begin
      failures++;
      $display("FAIL t4_clr got ovf=%0b fault=%0b expected 0 0", ifc.o_overflow, ifc.o_fault);
    end
    // FIFO is full and the FSM pops this cycle: the write must be accepted.
    c = $urandom_range(15, 1);
    exp_q.push_back(c);
    push_code(c);
    checks++;
    if (ifc.o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL t4_write_on_pop got ovf=%0b expected 0", ifc.o_overflow);
    end
    push_done = 1;
    run_hopper(2, 2000);
  endtask

  task automatic test_misc();
    ifc.i_no_change = 1'b1;
    push_code(5);
    ifc.i_no_change = 1'b0;
    checks++;
    if (ifc.o_shortage !== 1'b1 || ifc.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL t5_shortage got short=%0b busy=%0b expected 1 0", ifc.o_shortage, ifc.o_busy);
    end
    push_code(0);
    tick();
    checks++;
    if (ifc.o_busy !== 1'b0 || ifc.o_eject_req !== 1'b0) begin
      failures++;
      $display("FAIL t5_code_zero got busy=%0b req=%0b expected 0 0", ifc.o_busy, ifc.o_eject_req);
    end
    ifc.i_eject_done = 1'b1;
    tick();
    ifc.i_eject_done = 1'b0;
    checks++;
    if (ifc.o_dispensed_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL t5_idle_done got cnt=%0d expected %0d", ifc.o_dispensed_cnt, 8'(exp_cnt));
    end
    ifc.i_fault_clr = 1'b1;
    ifc.i_no_change = 1'b1;
    push_code(2);
    ifc.i_no_change = 1'b0;
    checks++;
    if (ifc.o_shortage !== 1'b1) begin
      failures++;
      $display("FAIL t5_set_beats_clr got %0b expected 1", ifc.o_shortage);
    end
    tick();
    ifc.i_fault_clr = 1'b0;
    checks++;
    if (ifc.o_shortage !== 1'b0) begin
      failures++;
      $display("FAIL t5_clr got %0b expected 0", ifc.o_shortage);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    push_code(4);
    push_code(6);
    push_code(8);
    while (!ifc.o_eject_req && n < 20) begin tick(); n++; end
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({ifc.o_eject_req, ifc.o_busy, ifc.o_fault, ifc.o_overflow, ifc.o_shortage} !== 5'b0 ||
        ifc.o_eject_code !== 4'd0 || ifc.o_dispensed_cnt !== 8'd0) begin
      failures++;
      $display("FAIL t6_async_reset got req=%0b busy=%0b code=%0d cnt=%0d expected all 0",
               ifc.o_eject_req, ifc.o_busy, ifc.o_eject_code, ifc.o_dispensed_cnt);
    end
    exp_cnt = 0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ifc.o_busy !== 1'b0 || ifc.o_eject_req !== 1'b0) begin
      failures++;
      $display("FAIL t6_fifo_empty got busy=%0b req=%0b expected 0 0", ifc.o_busy, ifc.o_eject_req);
    end
    exp_q.push_back(11);
    push_code(11);
    push_done = 1;
    run_hopper(3, 200);
  endtask

  task automatic test_random();
    bit exp_short;
    exp_short = 0;
    push_done = 0;
    fork
      begin
        int c;
        bit nc;
        for (int i = 0; i < 12; i++) begin
          c  = $urandom_range(15, 0);
          nc = ($urandom_range(5, 0) == 0);
          if (nc) exp_short = 1;
          else if (c != 0) exp_q.push_back(c);
          ifc.i_no_change = nc;
          push_code(c);
          ifc.i_no_change = 1'b0;
          repeat ($urandom_range(6, 0)) tick();
        end
        push_done = 1;
      end
      run_hopper(4, 3000);
    join
    checks++;
    if (ifc.o_shortage !== exp_short || ifc.o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL rand_flags got short=%0b ovf=%0b expected %0b 0", ifc.o_shortage, ifc.o_overflow, exp_short);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_misc();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
